// File: rtl/md_pkg.sv
// md_pkg: shared operation encodings, FSM states and result field layout for the issue sequencer
package md_pkg;
  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;
  localparam logic [127:0] DZ_QUOT = '1;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;
  function automatic int hi_lsb(int w);
    return w;
  endfunction
  function automatic int hi_msb(int w);
    return 2 * w - 1;
  endfunction
  function automatic int lo_lsb(int w);
    return hi_lsb(w) - w;
  endfunction
endpackage

// File: rtl/md_issue_sequencer_if.sv
// md_issue_sequencer_if: request, mul/div unit and response signals of the issue sequencer
interface md_issue_sequencer_if #(parameter int W = 64, parameter int TAG_W = 4);
  logic req_valid;
  logic req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic req_op;
  logic [TAG_W-1:0] req_tag;
  logic [W-1:0] md_a;
  logic [W-1:0] md_b;
  logic md_op;
  logic md_start;
  logic md_ready;
  logic [2*W:0] md_result;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_lo;
  logic [W-1:0] rsp_hi;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_dz;
  logic busy;
  modport slave (
    input req_valid, req_a, req_b, req_op, req_tag, md_ready, md_result, rsp_ready,
    output req_ready, md_a, md_b, md_op, md_start, rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_dz, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, md_ready, md_result, rsp_ready,
    input req_ready, md_a, md_b, md_op, md_start, rsp_valid, rsp_lo, rsp_hi, rsp_tag, rsp_dz, busy
  );
endinterface

// File: rtl/md_req_fifo.sv
// md_req_fifo: synchronous request FIFO with full/empty flags and wrap-around pointers
module md_req_fifo #(parameter int WIDTH = 8, parameter int DEPTH = 4) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign dout = mem_q[rd_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_comb begin
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/md_issue_sequencer.sv
// md_issue_sequencer: buffers mul/div requests, issues them one at a time and holds the response
module md_issue_sequencer
  import md_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic reset,
  md_issue_sequencer_if.slave bus
);
  localparam int FW = 2 * W + 1 + TAG_W;
  localparam int LO = lo_lsb(W);
  localparam int HL = hi_lsb(W);
  localparam int HM = hi_msb(W);
  logic [FW-1:0] head;
  logic empty, full, push, pop;
  logic [W-1:0] h_a, h_b;
  logic h_op, h_dz;
  logic [TAG_W-1:0] h_tag;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d, hi_q, hi_d;
  logic op_q, op_d, start_q, start_d, valid_q, valid_d, dz_q, dz_d;
  logic [TAG_W-1:0] tag_q, tag_d, rtag_q, rtag_d;
  assign bus.req_ready = !full && reset;
  assign push = bus.req_valid && bus.req_ready;
  assign {h_tag, h_op, h_b, h_a} = head;
  assign h_dz = h_op == OP_DIV && h_b == '0;
  md_req_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({bus.req_tag, bus.req_op, bus.req_b, bus.req_a}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    tag_d = tag_q;
    lo_d = lo_q;
    hi_d = hi_q;
    rtag_d = rtag_q;
    dz_d = dz_q;
    valid_d = valid_q;
    start_d = 1'b0;
    pop = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop = 1'b1;
        if (h_dz) begin
          lo_d = DZ_QUOT[W-1:0];
          hi_d = h_a;
          rtag_d = h_tag;
          dz_d = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          a_d = h_a;
          b_d = h_b;
          op_d = h_op;
          tag_d = h_tag;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: if (bus.md_ready) begin
        lo_d = bus.md_result[LO +: W];
        hi_d = bus.md_result[HM:HL];
        rtag_d = tag_q;
        dz_d = 1'b0;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      default: if (bus.rsp_ready) begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      tag_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      rtag_q <= '0;
      dz_q <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tag_q <= tag_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      rtag_q <= rtag_d;
      dz_q <= dz_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end
  assign bus.md_a = a_q;
  assign bus.md_b = b_q;
  assign bus.md_op = op_q;
  assign bus.md_start = start_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_lo = lo_q;
  assign bus.rsp_hi = hi_q;
  assign bus.rsp_tag = rtag_q;
  assign bus.rsp_dz = dz_q;
  assign bus.busy = state_q != ST_IDLE || !empty;
endmodule
